instr_fetch: RTL and testbench

Instruction fetch stage that sits directly downstream of pc_updater. It consumes each new program counter and issues one word read to instruction memory. It buffers the returned instruction together with its PC and hands it to the decoder through a valid/ready interface. It handles misaligned PCs and pipeline flushes on redirect, including dropping an in-flight memory response.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the instruction fetch stage
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch buffer FIFO of fetch entries with flush and occupancy count
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output fetch_entry_t    head_o,
    output logic [CW-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Flush wins over any same-cycle push or pop.
    assign do_pop  = pop_i && !flush_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC in, one-word imem read, buffered instruction out
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int              XLEN      = rv32i_pkg::XLEN,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            misalign_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic            req_q;

    logic            pc_accept;
    logic            pc_misaligned;
    logic            resp_push;
    logic            fifo_push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [CW-1:0]   count;

    // Accepting only below DEPTH reserves a slot for the single outstanding response.
    assign pc_ready_o    = rst_n && (state_q == IDLE) && (count < CW'(DEPTH)) && !flush_i;
    assign pc_accept     = pc_valid_i && pc_ready_o;
    assign pc_misaligned = (pc_i[1:0] != 2'b00);
    assign resp_push     = (state_q == WAIT) && imem_rvalid_i;
    assign fifo_push     = resp_push || (pc_accept && pc_misaligned);

    always_comb begin
        push_entry = '0;
        if (resp_push) begin
            push_entry.pc       = pc_q;
            push_entry.instr    = imem_rdata_i;
            push_entry.misalign = 1'b0;
        end else begin
            push_entry.pc       = pc_i;
            push_entry.instr    = NOP_INSTR;
            push_entry.misalign = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_accept && !pc_misaligned) begin
                        pc_q    <= pc_i;
                        addr_q  <= {pc_i[XLEN-1:2], 2'b00};
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= imem_gnt_i ? DRAIN : IDLE;
                    end else if (imem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= IDLE;
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The orphaned response is swallowed here; later flushes only clear the buffer.
                    if (imem_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (instr_valid_o && instr_ready_i),
        .flush_i     (flush_i),
        .head_o      (head),
        .count_o     (count)
    );

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? head.instr    : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc       : '0;
    assign misalign_o    = instr_valid_o ? head.misalign : 1'b0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a simple imem responder
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .misalign_o    (misalign_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   gnt_delay = 0;
    int   rv_delay  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        if (a == 32'h0000_0020) return 32'hDEAD_BEEF;
        return {a[15:0], 16'h0a13} ^ 32'h1357_0000;
    endfunction

    // Memory responder: grant after gnt_delay cycles of request, data rv_delay cycles after grant.
    logic        pend;
    logic [31:0] pend_addr;
    int          rv_cnt;
    int          g_cnt;
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        pend          = 1'b0;
        pend_addr     = '0;
        rv_cnt        = 0;
        g_cnt         = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            if (!rst_n) begin
                pend  = 1'b0;
                g_cnt = 0;
            end else if (pend) begin
                if (rv_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_data(pend_addr);
                    pend          = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (imem_req_o) begin
                if (g_cnt >= gnt_delay) begin
                    imem_gnt_i = 1'b1;
                    pend       = 1'b1;
                    pend_addr  = imem_addr_o;
                    rv_cnt     = rv_delay;
                    g_cnt      = 0;
                end else begin
                    g_cnt++;
                end
            end else begin
                g_cnt = 0;
            end
        end
    end

    // Scoreboard consumer: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && instr_valid_o && instr_ready_i && !flush_i) begin
            check("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc_o, e.pc);
                check("sb_instr", instr_o, e.instr);
                check("sb_misalign", {31'b0, misalign_o}, {31'b0, e.mis});
            end
        end
    end

    task automatic send_pc(input logic [31:0] pc, input bit expect_out);
        int   n;
        exp_t e;
        n          = 0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (pc_ready_o) break;
            n++;
            if (n > 200) begin
                check("pc_ready_timeout", {31'b0, pc_ready_o}, 32'd1);
                break;
            end
        end
        if (expect_out) begin
            e.pc    = pc;
            e.mis   = (pc[1:0] != 2'b00);
            e.instr = e.mis ? 32'h0000_0013 : mem_data(pc);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pc_valid_i = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drained", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
        check({tag, "_addr"}, imem_addr_o, 32'd0);
        check({tag, "_pc_ready"}, {31'b0, pc_ready_o}, 32'd0);
        check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
        check({tag, "_instr"}, instr_o, 32'd0);
        check({tag, "_instr_pc"}, instr_pc_o, 32'd0);
        check({tag, "_misalign"}, {31'b0, misalign_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit seen_rv;
        bit saw_req;
        bit drained;

        rst_n         = 1'b0;
        pc_i          = '0;
        pc_valid_i    = 1'b0;
        flush_i       = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch with latency check.
        send_pc(32'h0000_0010, 1'b1);
        @(negedge clk);
        check("t1_req", {31'b0, imem_req_o}, 32'd1);
        check("t1_addr", imem_addr_o, 32'h0000_0010);
        check("t1_valid_n1", {31'b0, instr_valid_o}, 32'd0);
        @(negedge clk);
        check("t1_valid_n2", {31'b0, instr_valid_o}, 32'd0);
        @(negedge clk);
        check("t1_valid_n3", {31'b0, instr_valid_o}, 32'd1);
        check("t1_instr", instr_o, 32'h0050_0093);
        check("t1_pc", instr_pc_o, 32'h0000_0010);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        wait_empty();

        // Backpressure: two entries fill the buffer, third PC must wait.
        instr_ready_i = 1'b0;
        send_pc(32'h0000_0000, 1'b1);
        send_pc(32'h0000_0004, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        pc_i       = 32'h0000_0008;
        pc_valid_i = 1'b1;
        saw_req    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req_o) saw_req = 1'b1;
            check("t2_pc_ready_full", {31'b0, pc_ready_o}, 32'd0);
            check("t2_head_stable", instr_pc_o, 32'h0000_0000);
        end
        check("t2_no_req_full", {31'b0, saw_req}, 32'd0);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        send_pc(32'h0000_0008, 1'b1);
        wait_empty();

        // Misaligned PC bypasses memory.
        instr_ready_i = 1'b0;
        send_pc(32'h0000_0006, 1'b1);
        @(negedge clk);
        check("t3_no_req", {31'b0, imem_req_o}, 32'd0);
        check("t3_valid", {31'b0, instr_valid_o}, 32'd1);
        check("t3_instr", instr_o, 32'h0000_0013);
        check("t3_misalign", {31'b0, misalign_o}, 32'd1);
        check("t3_pc", instr_pc_o, 32'h0000_0006);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        wait_empty();

        // Flush in WAIT: late response must be dropped.
        rv_delay = 3;
        send_pc(32'h0000_0020, 1'b0);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("t4_pc_ready_flush", {31'b0, pc_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        seen_rv = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pc_ready_o) begin
                drained = 1'b1;
                break;
            end
            if (imem_rvalid_i) seen_rv = 1'b1;
        end
        check("t4_drained", {31'b0, drained}, 32'd1);
        check("t4_rvalid_before_ready", {31'b0, seen_rv}, 32'd1);
        check("t4_valid_after", {31'b0, instr_valid_o}, 32'd0);
        rv_delay = 0;
        @(posedge clk);
        #1;

        // Flush with a full buffer and a simultaneous pop.
        instr_ready_i = 1'b0;
        send_pc(32'h0000_0040, 1'b1);
        send_pc(32'h0000_0044, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_valid_full", {31'b0, instr_valid_o}, 32'd1);
        check("t5_pc_ready_full", {31'b0, pc_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        flush_i       = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("t5_valid_flushed", {31'b0, instr_valid_o}, 32'd0);
        check("t5_pc_ready_flushed", {31'b0, pc_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-WAIT.
        rv_delay = 3;
        send_pc(32'h0000_0030, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rv_delay = 0;
        @(posedge clk);
        #1;
        send_pc(32'h0000_0000, 1'b1);
        wait_empty();
        check("end_valid", {31'b0, instr_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
